fmv_pixel_strobe_gen: RTL and testbench
=======================================

Name: fmv_pixel_strobe_gen

Overview:
Programmable fractional-rate pixel strobe generator (NCO) for the FMV/MPEG video path. It derives per-pixel enable pulses from the 30 MHz system clock using a phase accumulator with a parametrised fractional width. Supported rates are Green Book (30 MHz base case), White Book/VCD (about 13.5 MHz) and a software override increment. Unlike a free-running divider, it re-aligns phase at every line start, counts pixels per line, stops after a programmable width, and switches rate only at line boundaries so a line never mixes two rates.

Parameters:
- FRAC_W, 8: accumulator fractional width; unity increment = 2**FRAC_W.
- PIX_W, 10: width of pixel counter and line_width.
- BASE_INC, 256: increment for base case; must be ≤ 2**FRAC_W.
- VCD_INC, 231: increment for vcd_mode (13.5/15 scaling, rounded to keep full 352-pixel footage).

Ports:
- clk30, in, 1: 30 MHz system clock.
- reset, in, 1: synchronous, active-high reset.
- vcd_mode, in, 1: selects VCD_INC when no override is present.
- inc_override_valid, in, 1: use inc_override instead of mode-derived increment.
- inc_override, in, FRAC_W+1: override increment.
- line_start, in, 1: single-cycle pulse that re-aligns phase and starts a line.
- line_width, in, PIX_W: number of strobes per line; sampled at line_start.
- newpixel, out, 1: pixel enable pulse.
- pixel_x, out, PIX_W: index of the pixel qualified by newpixel.
- line_active, out, 1: high while in ACTIVE.
- line_done, out, 1: one-cycle pulse coincident with the last newpixel of a line.
- active_inc, out, FRAC_W+1: increment in use for the current line.

Behaviour:
- Clock and reset: one clock, clk30. reset is synchronous and active-high. All state is registered.
- Reset values: acc=0, count=0, state=IDLE, active_inc=BASE_INC, width_q=0, newpixel=0, pixel_x=0, line_done=0. line_active=0 because it decodes state.
- Increment select (combinational): sel = inc_override_valid ? clamp(inc_override) : (vcd_mode ? VCD_INC : BASE_INC). clamp saturates values above 2**FRAC_W to 2**FRAC_W. An increment of 0 is legal and produces no strobes.
- States: IDLE and ACTIVE.
- IDLE:
  - acc holds its value.
  - newpixel and line_done are 0.
  - On line_start: acc<=0, count<=0, width_q<=line_width, active_inc<=sel. Go to ACTIVE if line_width≠0. If line_width=0, stay IDLE and pulse line_done on the next cycle with no strobes.
- ACTIVE, per cycle:
  - sum = acc + active_inc, computed at FRAC_W+1 bits.
  - acc <= sum[FRAC_W-1:0].
  - If sum[FRAC_W]=1: newpixel<=1, pixel_x<=count, count<=count+1.
  - If count+1==width_q on that same strobe: line_done<=1 and state<=IDLE.
- Latency: line_start at cycle k. With increment 2**FRAC_W, the first newpixel appears at k+2, then every cycle after.
- line_start while ACTIVE: abort and restart exactly as from IDLE (re-align, resample width and increment). No line_done is emitted for the aborted line. line_start has priority over a coincident strobe.
- Rate changes: vcd_mode and override changes mid-line have no effect until the next line_start.
- Ordering: pixel_x is strictly 0..width_q-1 within a line, with no wrap.
- Reset: reset mid-line returns all outputs to reset values on the next edge. Any in-flight pulse is dropped.
- Long-run rate: strobe count over N ACTIVE cycles is floor(N*active_inc/2**FRAC_W), with error of at most 1.

Decomposition:
- Package fmv_pkg holds FRAC_W and PIX_W defaults, BASE_INC, VCD_INC, and the state enum typedef (IDLE, ACTIVE). The sample_rate_converter constants migrate there.
- One natural sub-module, phase_nco: accumulator, clamp and carry output. It has a clear/load input and enable. The top level holds the line FSM and counter.

Test Plan:
- Reset, vcd_mode=0, line_width=4, line_start at k -> newpixel high k+2..k+5, pixel_x 0,1,2,3, line_done at k+5 only, active_inc=256.
- vcd_mode=1, line_width=1023, line_start -> exactly 902 strobes within 1000 cycles after k+1, active_inc=231, pixel_x monotonic.
- Override 128 valid, width 3 -> newpixel at k+3, k+5, k+7. Override 300 -> clamped to 256, strobes every cycle. Override 0 -> no strobes and no line_done.
- Toggle vcd_mode mid-line -> spacing unchanged until the next line_start. The next line uses the new increment.
- Second line_start mid-line -> acc re-aligned, pixel_x restarts at 0, no line_done for the aborted line. line_width=0 -> line_done one cycle later with no newpixel.
- Assert reset during ACTIVE -> next cycle newpixel=0, line_active=0, pixel_x=0, active_inc=256. A subsequent line_start behaves as in the first scenario.

Source files
------------

// File: rtl/fmv_pkg.sv
// Shared constants and types for the FMV pixel strobe path.
// Holds the default accumulator geometry and the per-standard pixel-rate increments.
package fmv_pkg;

   localparam int FMV_FRAC_W   = 8;
   localparam int FMV_PIX_W    = 10;
   localparam int FMV_BASE_INC = 256;
   // 13.5/15 of unity, rounded so a full 352-pixel VCD line still fits.
   localparam int FMV_VCD_INC  = 231;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } line_state_t;

endpackage

// File: rtl/fmv_pixel_strobe_gen_phase_nco.sv
// Phase accumulator for the pixel strobe generator.
// Produces the carry that becomes a pixel strobe and clamps raw increments to unity.
module phase_nco
   import fmv_pkg::*;
#(
   parameter int FRAC_W = FMV_FRAC_W
)
(
   input  logic              clk30,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   input  logic [FRAC_W:0]   inc,
   input  logic [FRAC_W:0]   raw_inc,
   output logic [FRAC_W:0]   clamped_inc,
   output logic              carry
);

   localparam logic [FRAC_W:0] UNITY = {1'b1, {FRAC_W{1'b0}}};

   logic [FRAC_W-1:0] acc_reg;
   logic [FRAC_W-1:0] acc_next;
   logic [FRAC_W:0]   sum;

   // inc never exceeds unity, so one extra bit holds the whole sum.
   always_comb begin
      sum      = {1'b0, acc_reg} + inc;
      carry    = en & sum[FRAC_W];
      acc_next = acc_reg;
      if (clear) begin
         acc_next = '0;
      end else if (en) begin
         acc_next = sum[FRAC_W-1:0];
      end
   end

   assign clamped_inc = (raw_inc > UNITY) ? UNITY : raw_inc;

   always_ff @(posedge clk30) begin
      if (reset) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_next;
      end
   end

endmodule

// File: rtl/fmv_pixel_strobe_gen.sv
// Fractional-rate pixel strobe generator: line FSM and pixel counter around a phase NCO.
// Phase, width and rate are all captured at line_start so a line never mixes two rates.
module fmv_pixel_strobe_gen
   import fmv_pkg::*;
#(
   parameter int FRAC_W   = FMV_FRAC_W,
   parameter int PIX_W    = FMV_PIX_W,
   parameter int BASE_INC = FMV_BASE_INC,
   parameter int VCD_INC  = FMV_VCD_INC
)
(
   input  logic              clk30,
   input  logic              reset,
   input  logic              vcd_mode,
   input  logic              inc_override_valid,
   input  logic [FRAC_W:0]   inc_override,
   input  logic              line_start,
   input  logic [PIX_W-1:0]  line_width,
   output logic              newpixel,
   output logic [PIX_W-1:0]  pixel_x,
   output logic              line_active,
   output logic              line_done,
   output logic [FRAC_W:0]   active_inc
);

   localparam logic [FRAC_W:0] BASE_INC_W = (FRAC_W+1)'(BASE_INC);
   localparam logic [FRAC_W:0] VCD_INC_W  = (FRAC_W+1)'(VCD_INC);

   line_state_t       state_reg, state_next;
   logic [PIX_W-1:0]  count_reg, count_next;
   logic [PIX_W-1:0]  width_reg, width_next;
   logic [FRAC_W:0]   inc_reg, inc_next;
   logic              newpixel_reg, newpixel_next;
   logic [PIX_W-1:0]  pixel_x_reg, pixel_x_next;
   logic              done_reg, done_next;

   logic              nco_clear;
   logic              nco_en;
   logic              carry;
   logic [FRAC_W:0]   clamped_inc;
   logic [FRAC_W:0]   sel_inc;
   logic              last_pixel;

   phase_nco #(
      .FRAC_W (FRAC_W)
   ) u_nco (
      .clk30       (clk30),
      .reset       (reset),
      .clear       (nco_clear),
      .en          (nco_en),
      .inc         (inc_reg),
      .raw_inc     (inc_override),
      .clamped_inc (clamped_inc),
      .carry       (carry)
   );

   assign sel_inc    = inc_override_valid ? clamped_inc : (vcd_mode ? VCD_INC_W : BASE_INC_W);
   assign last_pixel = ((PIX_W+1)'(count_reg) + (PIX_W+1)'(1)) == (PIX_W+1)'(width_reg);

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      width_next    = width_reg;
      inc_next      = inc_reg;
      newpixel_next = 1'b0;
      pixel_x_next  = pixel_x_reg;
      done_next     = 1'b0;
      nco_clear     = 1'b0;
      nco_en        = 1'b0;

      // A restart wins over any strobe due this cycle; the aborted line gets no line_done.
      if (line_start) begin
         nco_clear  = 1'b1;
         count_next = '0;
         width_next = line_width;
         inc_next   = sel_inc;
         if (line_width != '0) begin
            state_next = ACTIVE;
         end else begin
            state_next = IDLE;
            done_next  = 1'b1;
         end
      end else if (state_reg == ACTIVE) begin
         nco_en = 1'b1;
         if (carry) begin
            newpixel_next = 1'b1;
            pixel_x_next  = count_reg;
            count_next    = count_reg + PIX_W'(1);
            if (last_pixel) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk30) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         width_reg    <= '0;
         inc_reg      <= BASE_INC_W;
         newpixel_reg <= 1'b0;
         pixel_x_reg  <= '0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         width_reg    <= width_next;
         inc_reg      <= inc_next;
         newpixel_reg <= newpixel_next;
         pixel_x_reg  <= pixel_x_next;
         done_reg     <= done_next;
      end
   end

   assign newpixel    = newpixel_reg;
   assign pixel_x     = pixel_x_reg;
   assign line_done   = done_reg;
   assign line_active = (state_reg == ACTIVE);
   assign active_inc  = inc_reg;

endmodule

// File: tb/tb_fmv_pixel_strobe_gen.sv
// Self-checking bench for fmv_pixel_strobe_gen against an arithmetic model of strobe timing.
// Sample m of a line is taken 1 ns after the m-th rising edge following line_start.
module tb_fmv_pixel_strobe_gen;

   localparam int UNITY = 256;

   logic       clk30 = 1'b0;
   logic       reset = 1'b1;
   logic       vcd_mode = 1'b0;
   logic       inc_override_valid = 1'b0;
   logic [8:0] inc_override = '0;
   logic       line_start = 1'b0;
   logic [9:0] line_width = '0;
   logic       newpixel;
   logic [9:0] pixel_x;
   logic       line_active;
   logic       line_done;
   logic [8:0] active_inc;

   int tests = 0;
   int fails = 0;

   always #5 clk30 = ~clk30;

   fmv_pixel_strobe_gen dut (
      .clk30              (clk30),
      .reset              (reset),
      .vcd_mode           (vcd_mode),
      .inc_override_valid (inc_override_valid),
      .inc_override       (inc_override),
      .line_start         (line_start),
      .line_width         (line_width),
      .newpixel           (newpixel),
      .pixel_x            (pixel_x),
      .line_active        (line_active),
      .line_done          (line_done),
      .active_inc         (active_inc)
   );

   typedef struct packed {
      logic np;
      logic done;
      logic act;
      int   px;
   } exp_t;

   // Strobes owed after j ACTIVE cycles at the given increment.
   function automatic int strobes(int j, int inc);
      return (j <= 0) ? 0 : (j * inc) / UNITY;
   endfunction

   function automatic exp_t expect_at(int m, int w, int inc);
      exp_t e;
      int c = strobes(m - 1, inc);
      int p = strobes(m - 2, inc);
      e.np   = (m >= 2) && (c > p) && (c <= w);
      e.px   = c - 1;
      e.done = (w == 0) ? (m == 1) : (e.np && (c == w));
      e.act  = (w != 0) && (c < w);
      return e;
   endfunction

   function automatic int model_inc(logic vcd, logic ov, int ovr);
      if (ov) return (ovr > UNITY) ? UNITY : ovr;
      return vcd ? 231 : 256;
   endfunction

   task automatic tick();
      @(posedge clk30);
      #1;
   endtask

   task automatic launch(input int w);
      line_start = 1'b1;
      line_width = w[9:0];
      tick();
      line_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tests++; if (newpixel !== 1'b0) begin fails++; $display("FAIL reset_newpixel got %b want 0", newpixel); end
      tests++; if (pixel_x !== 10'd0) begin fails++; $display("FAIL reset_pixel_x got %0d want 0", pixel_x); end
      tests++; if (line_active !== 1'b0) begin fails++; $display("FAIL reset_line_active got %b want 0", line_active); end
      tests++; if (line_done !== 1'b0) begin fails++; $display("FAIL reset_line_done got %b want 0", line_done); end
      tests++; if (active_inc !== 9'd256) begin fails++; $display("FAIL reset_active_inc got %0d want 256", active_inc); end
   endtask

   task automatic test_base_line();
      exp_t e;
      int np_cnt = 0;
      vcd_mode = 1'b0;
      inc_override_valid = 1'b0;
      launch(4);
      tests++; if (active_inc !== 9'd256) begin fails++; $display("FAIL base_inc got %0d want 256", active_inc); end
      for (int m = 1; m <= 9; m++) begin
         e = expect_at(m, 4, 256);
         np_cnt += int'(newpixel);
         tests++; if (newpixel !== e.np) begin fails++; $display("FAIL base_np m=%0d got %b want %b", m, newpixel, e.np); end
         tests++; if (line_done !== e.done) begin fails++; $display("FAIL base_done m=%0d got %b want %b", m, line_done, e.done); end
         tests++; if (line_active !== e.act) begin fails++; $display("FAIL base_act m=%0d got %b want %b", m, line_active, e.act); end
         if (e.np) begin
            tests++; if (pixel_x !== e.px[9:0]) begin fails++; $display("FAIL base_px m=%0d got %0d want %0d", m, pixel_x, e.px); end
         end
         tick();
      end
      tests++; if (np_cnt != 4) begin fails++; $display("FAIL base_count got %0d want 4", np_cnt); end
   endtask

   task automatic test_vcd_rate();
      exp_t e;
      int np_cnt = 0;
      vcd_mode = 1'b1;
      inc_override_valid = 1'b0;
      launch(1023);
      tests++; if (active_inc !== 9'd231) begin fails++; $display("FAIL vcd_inc got %0d want 231", active_inc); end
      for (int m = 1; m <= 1001; m++) begin
         e = expect_at(m, 1023, 231);
         if (m >= 2) np_cnt += int'(newpixel);
         tests++; if (newpixel !== e.np) begin fails++; $display("FAIL vcd_np m=%0d got %b want %b", m, newpixel, e.np); end
         if (e.np) begin
            tests++; if (pixel_x !== e.px[9:0]) begin fails++; $display("FAIL vcd_px m=%0d got %0d want %0d", m, pixel_x, e.px); end
         end
         tick();
      end
      tests++; if (np_cnt != 902) begin fails++; $display("FAIL vcd_count got %0d want 902", np_cnt); end
   endtask

   task automatic test_override();
      int ovr_tab[3] = '{128, 300, 0};
      int n_tab[3]   = '{12, 8, 20};
      exp_t e;
      vcd_mode = 1'b0;
      for (int t = 0; t < 3; t++) begin
         inc_override_valid = 1'b1;
         inc_override = ovr_tab[t][8:0];
         launch(3);
         tests++; if (active_inc !== 9'(model_inc(1'b0, 1'b1, ovr_tab[t]))) begin
            fails++; $display("FAIL ovr_inc ovr=%0d got %0d want %0d", ovr_tab[t], active_inc, model_inc(1'b0, 1'b1, ovr_tab[t]));
         end
         for (int m = 1; m <= n_tab[t]; m++) begin
            e = expect_at(m, 3, model_inc(1'b0, 1'b1, ovr_tab[t]));
            tests++; if (newpixel !== e.np) begin fails++; $display("FAIL ovr_np ovr=%0d m=%0d got %b want %b", ovr_tab[t], m, newpixel, e.np); end
            tests++; if (line_done !== e.done) begin fails++; $display("FAIL ovr_done ovr=%0d m=%0d got %b want %b", ovr_tab[t], m, line_done, e.done); end
            tests++; if (line_active !== e.act) begin fails++; $display("FAIL ovr_act ovr=%0d m=%0d got %b want %b", ovr_tab[t], m, line_active, e.act); end
            if (e.np) begin
               tests++; if (pixel_x !== e.px[9:0]) begin fails++; $display("FAIL ovr_px ovr=%0d m=%0d got %0d want %0d", ovr_tab[t], m, pixel_x, e.px); end
            end
            tick();
         end
      end
      inc_override_valid = 1'b0;
   endtask

   task automatic test_mode_toggle();
      exp_t e;
      vcd_mode = 1'b0;
      inc_override_valid = 1'b0;
      launch(12);
      for (int m = 1; m <= 16; m++) begin
         if (m == 3) vcd_mode = 1'b1;
         if (m == 6) begin inc_override_valid = 1'b1; inc_override = 9'd64; end
         e = expect_at(m, 12, 256);
         tests++; if (newpixel !== e.np) begin fails++; $display("FAIL toggle_np m=%0d got %b want %b", m, newpixel, e.np); end
         tests++; if (line_done !== e.done) begin fails++; $display("FAIL toggle_done m=%0d got %b want %b", m, line_done, e.done); end
         tests++; if (active_inc !== 9'd256) begin fails++; $display("FAIL toggle_inc m=%0d got %0d want 256", m, active_inc); end
         tick();
      end
      inc_override_valid = 1'b0;
      launch(10);
      tests++; if (active_inc !== 9'd231) begin fails++; $display("FAIL toggle_next_inc got %0d want 231", active_inc); end
      for (int m = 1; m <= 14; m++) begin
         e = expect_at(m, 10, 231);
         tests++; if (newpixel !== e.np) begin fails++; $display("FAIL toggle2_np m=%0d got %b want %b", m, newpixel, e.np); end
         tests++; if (line_done !== e.done) begin fails++; $display("FAIL toggle2_done m=%0d got %b want %b", m, line_done, e.done); end
         tick();
      end
   endtask

   task automatic test_restart();
      exp_t e;
      vcd_mode = 1'b1;
      inc_override_valid = 1'b0;
      launch(8);
      tick();
      tick();
      tick();
      // Restart with acc already off zero and a strobe due on the same edge.
      launch(5);
      for (int m = 1; m <= 10; m++) begin
         e = expect_at(m, 5, 231);
         tests++; if (newpixel !== e.np) begin fails++; $display("FAIL restart_np m=%0d got %b want %b", m, newpixel, e.np); end
         tests++; if (line_done !== e.done) begin fails++; $display("FAIL restart_done m=%0d got %b want %b", m, line_done, e.done); end
         if (e.np) begin
            tests++; if (pixel_x !== e.px[9:0]) begin fails++; $display("FAIL restart_px m=%0d got %0d want %0d", m, pixel_x, e.px); end
         end
         tick();
      end
      launch(0);
      for (int m = 1; m <= 4; m++) begin
         e = expect_at(m, 0, 231);
         tests++; if (newpixel !== e.np) begin fails++; $display("FAIL zero_np m=%0d got %b want %b", m, newpixel, e.np); end
         tests++; if (line_done !== e.done) begin fails++; $display("FAIL zero_done m=%0d got %b want %b", m, line_done, e.done); end
         tests++; if (line_active !== e.act) begin fails++; $display("FAIL zero_act m=%0d got %b want %b", m, line_active, e.act); end
         tick();
      end
   endtask

   task automatic test_reset_midline();
      vcd_mode = 1'b1;
      inc_override_valid = 1'b0;
      launch(50);
      for (int m = 0; m < 5; m++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++; if (newpixel !== 1'b0) begin fails++; $display("FAIL midreset_np got %b want 0", newpixel); end
      tests++; if (line_active !== 1'b0) begin fails++; $display("FAIL midreset_act got %b want 0", line_active); end
      tests++; if (pixel_x !== 10'd0) begin fails++; $display("FAIL midreset_px got %0d want 0", pixel_x); end
      tests++; if (active_inc !== 9'd256) begin fails++; $display("FAIL midreset_inc got %0d want 256", active_inc); end
      tests++; if (line_done !== 1'b0) begin fails++; $display("FAIL midreset_done got %b want 0", line_done); end
      test_base_line();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      vcd_mode = 1'b0;
      inc_override_valid = 1'b0;
      for (int l = 0; l < 4; l++) begin
         launch(2);
         for (int m = 1; m <= 3; m++) begin
            e = expect_at(m, 2, 256);
            tests++; if (newpixel !== e.np) begin fails++; $display("FAIL b2b_np line=%0d m=%0d got %b want %b", l, m, newpixel, e.np); end
            tests++; if (line_done !== e.done) begin fails++; $display("FAIL b2b_done line=%0d m=%0d got %b want %b", l, m, line_done, e.done); end
            if (e.np) begin
               tests++; if (pixel_x !== e.px[9:0]) begin fails++; $display("FAIL b2b_px line=%0d m=%0d got %0d want %0d", l, m, pixel_x, e.px); end
            end
            if (m < 3) tick();
         end
      end
      tick();
   endtask

   task automatic test_random();
      exp_t e;
      int w, ovr, inc, n;
      logic vcd, ov;
      for (int l = 0; l < 25; l++) begin
         vcd = 1'($urandom_range(0, 1));
         ov  = 1'($urandom_range(0, 1));
         ovr = $urandom_range(0, 511);
         w   = $urandom_range(0, 40);
         vcd_mode = vcd;
         inc_override_valid = ov;
         inc_override = ovr[8:0];
         inc = model_inc(vcd, ov, ovr);
         n = (inc == 0) ? 20 : (w * UNITY) / inc + 4;
         if (n > 150) n = 150;
         n = $urandom_range(2, n);
         launch(w);
         tests++; if (active_inc !== 9'(inc)) begin fails++; $display("FAIL rnd_inc line=%0d got %0d want %0d", l, active_inc, inc); end
         for (int m = 1; m <= n; m++) begin
            e = expect_at(m, w, inc);
            tests++; if (newpixel !== e.np) begin fails++; $display("FAIL rnd_np line=%0d m=%0d got %b want %b", l, m, newpixel, e.np); end
            tests++; if (line_done !== e.done) begin fails++; $display("FAIL rnd_done line=%0d m=%0d got %b want %b", l, m, line_done, e.done); end
            tests++; if (line_active !== e.act) begin fails++; $display("FAIL rnd_act line=%0d m=%0d got %b want %b", l, m, line_active, e.act); end
            if (e.np) begin
               tests++; if (pixel_x !== e.px[9:0]) begin fails++; $display("FAIL rnd_px line=%0d m=%0d got %0d want %0d", l, m, pixel_x, e.px); end
            end
            if (m < n) tick();
         end
      end
      inc_override_valid = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_base_line();
      test_vcd_rate();
      test_override();
      test_mode_toggle();
      test_restart();
      test_reset_midline();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
